tag_store_flush_wf: RTL and testbench
=====================================

# tag_store_flush_wf

Parametrised N-way, write-first tag store for the reference-prediction cache.
- Stores one tag per way per set and returns all ways of one set each cycle, with valid bits and a per-way tag-compare result.
- Adds three things over the fixed 8-way tag bank: per-way invalidate, a sequenced flush state machine, and an optional late-cycle write forward.
- Sits between the cache controller's set-index stage and its hit/miss decision logic.

## Interface
Parameters:
- TAG_WDTH, 16, tag width in bits
- SET_WDTH, 4, log2 of the number of sets
- LG_WAYS, 3, log2 of the number of ways (W = 1<<LG_WAYS)

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- r_addr_in  in  SET_WDTH  read set index
- cmp_tag_in  in  TAG_WDTH  lookup tag, sampled together with r_addr_in
- w_en_in  in  1  tag write strobe
- inv_en_in  in  1  invalidate strobe; shares the write address
- w_set_in  in  SET_WDTH  write/invalidate set
- w_way_in  in  LG_WAYS  write/invalidate way
- w_data_in  in  TAG_WDTH  tag to write
- flush_req_in  in  1  single-cycle request to invalidate every entry
- flush_busy_out  out  1  high while the flush sweep is running
- r_data_out  out  W*TAG_WDTH  tags of the read set; way i occupies bits [i*TAG_WDTH +: TAG_WDTH]
- valid_bits_out  out  W  valid bits of the read set
- hit_way_out  out  W  per-way match: valid and tag equal
- hit_out  out  1  OR of hit_way_out

## Operation
Storage:
- Tag RAM: 2^SET_WDTH x W entries, not reset.
- Valid array: 2^SET_WDTH words of W bits, written one set at a time, not reset.

FSM, two states:
- STATE_CLEAR: entered on reset assertion and from STATE_NORMAL on flush_req_in.
  - A SET_WDTH-bit counter starts at 0 and zeroes one valid word per cycle.
  - Leaves to STATE_NORMAL after the cycle that clears set 2^SET_WDTH-1.
  - Ignores w_en_in, inv_en_in and flush_req_in.
- STATE_NORMAL:
  - w_en_in writes the tag and sets the valid bit at (w_set_in, w_way_in).
  - inv_en_in alone clears that valid bit.
  - If w_en_in and inv_en_in are both high, the write wins: tag is stored, valid = 1.
  - flush_req_in moves to STATE_CLEAR; a write in the same cycle is dropped.

Read path:
- r_addr_in and cmp_tag_in are registered; the set's tags and valid bits are captured into output registers.
- Write-first capture: if a write or invalidate hits the same set in the read cycle, the captured way holds the new value.
- While flush_busy_out = 1, valid_bits_out is forced to 0, so hit_out = 0.

Hit logic:
- hit_way_out[i] = valid_bits_out[i] & (r_data_out way i == registered cmp_tag). Combinational from the outputs.
- Several ways may match; all are reported. Duplicate prevention is the controller's job.

## Timing
- Reset values: r_data_out = 0, valid_bits_out = 0, hit_way_out = 0, hit_out = 0, flush_busy_out = 1, FSM = STATE_CLEAR, counter = 0.
- Flush duration: exactly 2^SET_WDTH cycles of flush_busy_out = 1, counted from the first clk edge after reset deasserts, or from the edge that accepts flush_req_in.
- Reset asserted mid-sweep restarts the sweep at set 0.
- Read latency is 1 cycle: address at edge t gives data/valid/hit valid after edge t (cycle t+1).
- Same-cycle write (cycle t, same set as r_addr_in) is visible at cycle t+1.
- Next-cycle write (cycle t+1, same set as registered read) is handled per the Configuration section.
- Back-to-back writes to one way: the last write wins, one write per cycle.
- Set index wrap: the counter stops at 2^SET_WDTH-1 and does not wrap into a second pass.

## Configuration
- Macro TAG_STORE_LATE_FWD_EN defined: a write or invalidate in cycle t+1 to the registered read set is forwarded combinationally onto r_data_out, valid_bits_out and the hit outputs in the same cycle. This gives write-first behaviour across the full read window.
- Macro undefined: outputs are purely registered. A cycle t+1 write is visible only to a read issued at t+1 or later. There is no combinational path from w_* to any output.

## Test plan
- Reset then idle: flush_busy_out is 1 for 16 cycles, then 0; a read of set 5 returns valid_bits_out = 8'h00 and hit_out = 0.
- Write tag 16'hABCD to set 3, way 6; next cycle read set 3 with cmp_tag 16'hABCD: valid_bits_out = 8'h40, hit_way_out = 8'h40, hit_out = 1.
- Same-cycle write 16'h1234 to set 7, way 0 while reading set 7: at t+1, r_data_out way 0 = 16'h1234 and valid bit 0 = 1.
- Write 16'h5555 to set 2, way 1 in the cycle after a read of set 2 was issued:
  - With TAG_STORE_LATE_FWD_EN: way 1 shows 16'h5555 and valid in that cycle.
  - Without it: old value shown; a re-read shows 16'h5555.
- Fill set 9 ways 0..7; then assert inv_en_in and w_en_in together on way 2 (write wins), then inv_en_in alone on way 4: valid_bits_out = 8'hEF.
- flush_req_in after filling all sets: writes issued during the 16 busy cycles are dropped; afterwards every set reads valid_bits_out = 8'h00.

Source files
------------

// File: rtl/tag_store_flush_wf_if.sv
// Bus bundle for tag_store_flush_wf: lookup, write/invalidate, flush and read results.
// Parameters must match the ones given to the attached tag_store_flush_wf instance.
interface tag_store_flush_wf_if #(
    parameter int TAG_WDTH = 16,
    parameter int SET_WDTH = 4,
    parameter int LG_WAYS  = 3
);
    localparam int W = 1 << LG_WAYS;

    logic [SET_WDTH-1:0]   r_addr_in;
    logic [TAG_WDTH-1:0]   cmp_tag_in;
    logic                  w_en_in;
    logic                  inv_en_in;
    logic [SET_WDTH-1:0]   w_set_in;
    logic [LG_WAYS-1:0]    w_way_in;
    logic [TAG_WDTH-1:0]   w_data_in;
    logic                  flush_req_in;
    logic                  flush_busy_out;
    logic [W*TAG_WDTH-1:0] r_data_out;
    logic [W-1:0]          valid_bits_out;
    logic [W-1:0]          hit_way_out;
    logic                  hit_out;

    modport master (
        output r_addr_in, cmp_tag_in, w_en_in, inv_en_in, w_set_in, w_way_in,
               w_data_in, flush_req_in,
        input  flush_busy_out, r_data_out, valid_bits_out, hit_way_out, hit_out
    );

    modport slave (
        input  r_addr_in, cmp_tag_in, w_en_in, inv_en_in, w_set_in, w_way_in,
               w_data_in, flush_req_in,
        output flush_busy_out, r_data_out, valid_bits_out, hit_way_out, hit_out
    );
endinterface

// File: rtl/tag_store_flush_wf.sv
// N-way write-first tag store with per-way invalidate and a sequenced flush sweep.
// Optional macro TAG_STORE_LATE_FWD_EN forwards a write in the cycle after a read onto the outputs.
module tag_store_flush_wf #(
    parameter int TAG_WDTH = 16,
    parameter int SET_WDTH = 4,
    parameter int LG_WAYS  = 3
) (
    input logic                clk,
    input logic                reset,
    tag_store_flush_wf_if.slave bus
);
    localparam int W    = 1 << LG_WAYS;
    localparam int SETS = 1 << SET_WDTH;

    typedef enum logic {ST_CLEAR, ST_NORMAL} st_t;

    st_t                       st;
    logic [SET_WDTH-1:0]       cnt;
    logic                      busy;

    logic [W-1:0][TAG_WDTH-1:0] tags      [SETS];
    logic [W-1:0]               valid_arr [SETS];

    logic [SET_WDTH-1:0]        raddr_q;
    logic [TAG_WDTH-1:0]        cmp_q;
    logic [W-1:0][TAG_WDTH-1:0] rdata_q;
    logic [W-1:0]               vld_q;

    logic [W-1:0][TAG_WDTH-1:0] cap_data, data_o;
    logic [W-1:0]               cap_vld, vld_o, hit_way;
    logic                       wr_ok, inv_ok;

    // A flush request in the same cycle drops any write or invalidate.
    assign wr_ok  = (st == ST_NORMAL) && bus.w_en_in && !bus.flush_req_in;
    assign inv_ok = (st == ST_NORMAL) && bus.inv_en_in && !bus.flush_req_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st   <= ST_CLEAR;
            cnt  <= '0;
            busy <= 1'b1;
        end else begin
            case (st)
                ST_CLEAR: begin
                    if (cnt == SET_WDTH'(SETS - 1)) begin
                        st   <= ST_NORMAL;
                        busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (bus.flush_req_in) begin
                        st   <= ST_CLEAR;
                        busy <= 1'b1;
                        cnt  <= '0;
                    end
                end
            endcase
        end
    end

    // Storage arrays are not reset; the sweep owns initialising the valid bits.
    always_ff @(posedge clk) begin
        if (st == ST_CLEAR) begin
            valid_arr[cnt] <= '0;
        end else if (wr_ok) begin
            tags[bus.w_set_in][bus.w_way_in]      <= bus.w_data_in;
            valid_arr[bus.w_set_in][bus.w_way_in] <= 1'b1;
        end else if (inv_ok) begin
            valid_arr[bus.w_set_in][bus.w_way_in] <= 1'b0;
        end
    end

    always_comb begin
        cap_data = tags[bus.r_addr_in];
        cap_vld  = valid_arr[bus.r_addr_in];
        if (st == ST_CLEAR) begin
            cap_vld = '0;
        end else if (wr_ok && bus.w_set_in == bus.r_addr_in) begin
            cap_data[bus.w_way_in] = bus.w_data_in;
            cap_vld[bus.w_way_in]  = 1'b1;
        end else if (inv_ok && bus.w_set_in == bus.r_addr_in) begin
            cap_vld[bus.w_way_in] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raddr_q <= '0;
            cmp_q   <= '0;
            rdata_q <= '0;
            vld_q   <= '0;
        end else begin
            raddr_q <= bus.r_addr_in;
            cmp_q   <= bus.cmp_tag_in;
            rdata_q <= cap_data;
            vld_q   <= cap_vld;
        end
    end

    always_comb begin
        data_o = rdata_q;
        vld_o  = vld_q;
`ifdef TAG_STORE_LATE_FWD_EN
        if (wr_ok && bus.w_set_in == raddr_q) begin
            data_o[bus.w_way_in] = bus.w_data_in;
            vld_o[bus.w_way_in]  = 1'b1;
        end else if (inv_ok && bus.w_set_in == raddr_q) begin
            vld_o[bus.w_way_in] = 1'b0;
        end
`endif
        if (busy) vld_o = '0;
    end

    for (genvar i = 0; i < W; i++) begin : g_hit
        assign hit_way[i] = vld_o[i] && (data_o[i] == cmp_q);
    end

    assign bus.flush_busy_out = busy;
    assign bus.r_data_out     = data_o;
    assign bus.valid_bits_out = vld_o;
    assign bus.hit_way_out    = hit_way;
    assign bus.hit_out        = |hit_way;
endmodule

// File: tb/tb_tag_store_flush_wf.sv
// Directed bench for tag_store_flush_wf: reset sweep, reads, write-first, invalidate, flush.
// Expected values are hand-derived; late-forward expectations follow TAG_STORE_LATE_FWD_EN.
module tb_tag_store_flush_wf;
    localparam int TW = 16, SW = 4, LW = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   n;

    tag_store_flush_wf_if #(.TAG_WDTH(TW), .SET_WDTH(SW), .LG_WAYS(LW)) bus ();

    tag_store_flush_wf #(.TAG_WDTH(TW), .SET_WDTH(SW), .LG_WAYS(LW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] way_of(input logic [8*TW-1:0] d, input int w);
        return d[w*TW +: TW];
    endfunction

    task automatic wr(input int s, input int w, input logic [TW-1:0] d);
        bus.w_en_in   = 1'b1;
        bus.w_set_in  = SW'(s);
        bus.w_way_in  = LW'(w);
        bus.w_data_in = d;
        tick();
        bus.w_en_in   = 1'b0;
    endtask

    task automatic rd(input int s, input logic [TW-1:0] t);
        bus.r_addr_in  = SW'(s);
        bus.cmp_tag_in = t;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        n = 0;
        while (bus.flush_busy_out === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 128'(n), 128'd16);
    endtask

    initial begin
        reset = 1'b0;
        bus.r_addr_in = '0; bus.cmp_tag_in = '0; bus.w_en_in = 1'b0; bus.inv_en_in = 1'b0;
        bus.w_set_in = '0; bus.w_way_in = '0; bus.w_data_in = '0; bus.flush_req_in = 1'b0;
        repeat (3) tick();
        chk("rst_data", bus.r_data_out, 128'd0);
        chk("rst_vld", 128'(bus.valid_bits_out), 128'd0);
        chk("rst_hitway", 128'(bus.hit_way_out), 128'd0);
        chk("rst_hit", 128'(bus.hit_out), 128'd0);
        chk("rst_busy", 128'(bus.flush_busy_out), 128'd1);
        reset = 1'b1;
        wait_idle("rst_sweep_len");

        rd(5, 16'h0000);
        chk("idle_vld5", 128'(bus.valid_bits_out), 128'h00);
        chk("idle_hit5", 128'(bus.hit_out), 128'd0);

        wr(3, 6, 16'hABCD);
        rd(3, 16'hABCD);
        chk("s3_vld", 128'(bus.valid_bits_out), 128'h40);
        chk("s3_hitway", 128'(bus.hit_way_out), 128'h40);
        chk("s3_hit", 128'(bus.hit_out), 128'd1);
        chk("s3_data6", 128'(way_of(bus.r_data_out, 6)), 128'hABCD);

        // Write and read the same set in one cycle.
        bus.r_addr_in = 4'd7; bus.cmp_tag_in = 16'h1234;
        wr(7, 0, 16'h1234);
        chk("same_data0", 128'(way_of(bus.r_data_out, 0)), 128'h1234);
        chk("same_vld", 128'(bus.valid_bits_out), 128'h01);

        // Write in the cycle after a read of the same set was issued.
        wr(2, 1, 16'h1111);
        rd(2, 16'h5555);
        bus.w_en_in = 1'b1; bus.w_set_in = 4'd2; bus.w_way_in = 3'd1; bus.w_data_in = 16'h5555;
        #1;
`ifdef TAG_STORE_LATE_FWD_EN
        chk("late_data1", 128'(way_of(bus.r_data_out, 1)), 128'h5555);
        chk("late_hit", 128'(bus.hit_out), 128'd1);
`else
        chk("late_data1", 128'(way_of(bus.r_data_out, 1)), 128'h1111);
        chk("late_hit", 128'(bus.hit_out), 128'd0);
`endif
        chk("late_vld", 128'(bus.valid_bits_out), 128'h02);
        tick();
        bus.w_en_in = 1'b0;
        chk("reread_data1", 128'(way_of(bus.r_data_out, 1)), 128'h5555);

        for (int w = 0; w < 8; w++) wr(9, w, 16'h9000 + 16'(w));
        bus.inv_en_in = 1'b1;
        wr(9, 2, 16'h9AAA);
        bus.w_set_in = 4'd9; bus.w_way_in = 3'd4;
        tick();
        bus.inv_en_in = 1'b0;
        rd(9, 16'h9AAA);
        chk("inv_vld", 128'(bus.valid_bits_out), 128'hEF);
        chk("inv_hitway", 128'(bus.hit_way_out), 128'h04);
        chk("inv_data2", 128'(way_of(bus.r_data_out, 2)), 128'h9AAA);

        wr(10, 0, 16'h7777);
        wr(10, 5, 16'h7777);
        rd(10, 16'h7777);
        chk("multi_hitway", 128'(bus.hit_way_out), 128'h21);

        wr(11, 3, 16'h1111);
        wr(11, 3, 16'h2222);
        rd(11, 16'h2222);
        chk("b2b_data3", 128'(way_of(bus.r_data_out, 3)), 128'h2222);

        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 8; w++) wr(s, w, 16'(s * 16 + w));
        rd(12, 16'h00C5);
        chk("full_vld12", 128'(bus.valid_bits_out), 128'hFF);
        chk("full_hitway12", 128'(bus.hit_way_out), 128'h20);

        // Flush with a write in the same cycle, then keep writing during the sweep.
        bus.flush_req_in = 1'b1;
        wr(0, 0, 16'hDEAD);
        bus.flush_req_in = 1'b0;
        n = 0;
        while (bus.flush_busy_out === 1'b1 && n < 100) begin
            if (n == 3) chk("flush_vld_forced", 128'(bus.valid_bits_out), 128'h00);
            wr(n % 16, n % 8, 16'hBEEF);
            n++;
        end
        chk("flush_len", 128'(n), 128'd16);
        for (int s = 0; s < 16; s++) begin
            rd(s, 16'hBEEF);
            chk($sformatf("post_flush_vld%0d", s), 128'(bus.valid_bits_out), 128'h00);
        end
        chk("post_flush_hit", 128'(bus.hit_out), 128'd0);

        // Reset in the middle of a sweep restarts it from set 0.
        bus.flush_req_in = 1'b1;
        tick();
        bus.flush_req_in = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        chk("midrst_busy", 128'(bus.flush_busy_out), 128'd1);
        reset = 1'b1;
        wait_idle("midrst_sweep_len");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
